// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : AES constants, forward S-box table, byte indexing and stage FSM states
// Rev 1.0
// ============================================================================
package aes_pkg;

    localparam int NB      = 4;
    localparam int STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte index i = 4*col + row; byte i lives at bits [127-8*i -: 8].
    function automatic logic [3:0] byte_idx(input logic [1:0] col, input logic [1:0] row);
        return {col, row};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// aes_sbox : combinational FIPS-197 forward S-box, one byte in, one byte out
// Rev 1.0
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule
`default_nettype wire

// File: rtl/aes_sub_shift_stage.sv
`default_nettype none
// ============================================================================
// aes_sub_shift_stage : SubBytes + ShiftRows over a shared bank of LANES S-boxes
// Rev 1.0
// ============================================================================
module aes_sub_shift_stage
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data
);

    localparam int NCYC = 16 / LANES;

    state_t state;
    state_t state_next;

    logic [1:0]           cnt;
    logic                 cnt_last;
    logic [15:0][7:0]     src_reg;
    logic [15:0][7:0]     out_reg;
    logic [LANES-1:0][7:0] sb_in;
    logic [LANES-1:0][7:0] sb_out;
    logic [LANES-1:0][3:0] lane_dst;

    // Packed slot 15-i holds byte i, so slot order matches the bit layout of the bus.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam logic [1:0] ROW = 2'(l % 4);
            localparam logic [1:0] COL = 2'(l / 4);

            if (LANES == 4) begin : g_serial
                assign sb_in[l]    = src_reg[4'd15 - byte_idx(cnt + ROW, ROW)];
                assign lane_dst[l] = 4'd15 - byte_idx(cnt, ROW);
            end else begin : g_parallel
                assign sb_in[l]    = src_reg[4'd15 - byte_idx(COL + ROW, ROW)];
                assign lane_dst[l] = 4'd15 - byte_idx(COL, ROW);
            end

            aes_sbox u_sbox (
                .din  (sb_in[l]),
                .dout (sb_out[l])
            );
        end
    endgenerate

    assign cnt_last  = (cnt == 2'(NCYC - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = BUSY;
            BUSY:    if (cnt_last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 2'd0;
            src_reg <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src_reg <= in_data;
                        cnt     <= 2'd0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 2'd1;
                    for (int l = 0; l < LANES; l++) begin
                        out_reg[lane_dst[l]] <= sb_out[l];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
